ps2_host_tx: RTL

- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- It is the opposite direction of the keyboard receive path inside OperationEncoder, and shares the same PS2_CLK/PS2_DATA open-drain pins.
- Top instantiates it beside OperationEncoder. Its outputs are drive-low enables for the inout pins. `busy` tells the receive path to ignore line activity during a transmission.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_filter.sv | 72 +++++++
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side logic.
//   state_t       : host transmitter FSM states
//   ERR_*         : abort reason codes reported on err_code
//   CMD_*         : common keyboard command bytes
//   odd_parity()  : PS/2 parity bit for a data byte (odd parity over 9 bits)
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [1:0] ERR_NOCLK = 2'b01;
  localparam logic [1:0] ERR_BIT   = 2'b10;
  localparam logic [1:0] ERR_NOACK = 2'b11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning shared by the host transmitter and the receive path.
//   clk, rst   : system clock, synchronous active-low reset
//   clk_raw    : raw PS2_CLK pin level
//   data_raw   : raw PS2_DATA pin level
//   clk_filt   : synchronized CLK, accepted only after FILTER_CYCLES stable cycles
//   data_sync  : synchronized DATA (2 flops, no debounce)
//   data_filt  : synchronized DATA with the same debounce as CLK
//   fall       : one-cycle pulse when clk_filt goes 1->0
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_raw,
  input  logic data_raw,
  output logic clk_filt,
  output logic data_sync,
  output logic data_filt,
  output logic fall
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);

  logic          clk_p0, clk_p1, data_p0, data_p1;
  logic [FW-1:0] clk_cnt, data_cnt;

  // Synchronizers and debounce counters; lines idle high, so reset to 1
  // to avoid a spurious fall right after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_p0    <= 1'b1;
      clk_p1    <= 1'b1;
      data_p0   <= 1'b1;
      data_p1   <= 1'b1;
      clk_filt  <= 1'b1;
      data_filt <= 1'b1;
      clk_cnt   <= '0;
      data_cnt  <= '0;
      fall      <= 1'b0;
    end else begin
      clk_p0  <= clk_raw;
      clk_p1  <= clk_p0;
      data_p0 <= data_raw;
      data_p1 <= data_p0;
      fall    <= 1'b0;

      // A new level is taken only after it differed from the accepted
      // level for FILTER_CYCLES consecutive cycles.
      if (clk_p1 == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FW'(FILTER_CYCLES - 1)) begin
        clk_filt <= clk_p1;
        clk_cnt  <= '0;
        fall     <= ~clk_p1;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end

      if (data_p1 == data_filt) begin
        data_cnt <= '0;
      end else if (data_cnt == FW'(FILTER_CYCLES - 1)) begin
        data_filt <= data_p1;
        data_cnt  <= '0;
      end else begin
        data_cnt <= data_cnt + 1'b1;
      end
    end
  end

  assign data_sync = data_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// over the shared open-drain PS2_CLK/PS2_DATA pins.
//   clk, rst              : system clock, synchronous active-low reset
//   tx_valid, tx_data     : byte request; accepted when tx_valid && tx_ready
//   tx_ready              : high only while idle
//   ps2_clk_in/data_in    : raw pin levels
//   ps2_clk_oe/data_oe    : 1 = pull the pin low, 0 = release
//   busy                  : transfer in progress (receive path ignores the bus)
//   done                  : one-cycle pulse, byte sent and acknowledged
//   err, err_code         : one-cycle abort pulse; code held until next err
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES    = 12000,
  parameter int REQ_CYCLES        = 200,
  parameter int FIRST_CLK_TIMEOUT = 1500000,
  parameter int BIT_TIMEOUT       = 200000,
  parameter int FILTER_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int MAX_T0 = (FIRST_CLK_TIMEOUT > BIT_TIMEOUT) ? FIRST_CLK_TIMEOUT : BIT_TIMEOUT;
  localparam int MAX_T1 = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_T  = (MAX_T0 > MAX_T1) ? MAX_T0 : MAX_T1;
  localparam int CW     = $clog2(MAX_T + 1);

  logic          clk_filt, data_sync, data_filt, fall;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [9:0]    frame, frame_nxt;
  logic          data_oe_r, data_oe_nxt;
  logic          done_nxt, err_nxt;
  logic [1:0]    err_code_r, err_code_nxt;

  ps2_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .clk_raw  (ps2_clk_in),
    .data_raw (ps2_data_in),
    .clk_filt (clk_filt),
    .data_sync(data_sync),
    .data_filt(data_filt),
    .fall     (fall)
  );

  // State register; the latched frame is data and is not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      data_oe_r  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code_r <= 2'b00;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      data_oe_r  <= data_oe_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      err_code_r <= err_code_nxt;
    end
    frame <= frame_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    frame_nxt    = frame;
    data_oe_nxt  = data_oe_r;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    err_code_nxt = err_code_r;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          frame_nxt = {1'b1, odd_parity(tx_data), tx_data};
          cnt_nxt   = CW'(INHIBIT_CYCLES - 1);
          state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == '0) begin
          cnt_nxt     = CW'(REQ_CYCLES - 1);
          data_oe_nxt = 1'b1;  // start bit
          state_nxt   = REQ;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      REQ: begin
        if (cnt == '0) begin
          cnt_nxt   = CW'(FIRST_CLK_TIMEOUT - 1);
          idx_nxt   = '0;
          state_nxt = SHIFT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SHIFT: begin
        if (fall) begin
          data_oe_nxt = ~frame[idx];
          cnt_nxt     = CW'(BIT_TIMEOUT - 1);
          if (idx == 4'd9) state_nxt = ACK;
          else             idx_nxt   = idx + 1'b1;
        end else if (cnt == '0) begin
          // idx only leaves 0 on the first device fall.
          err_code_nxt = (idx == '0) ? ERR_NOCLK : ERR_BIT;
          err_nxt      = 1'b1;
          data_oe_nxt  = 1'b0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ACK: begin
        if (fall) begin
          if (!data_filt) begin
            cnt_nxt   = CW'(BIT_TIMEOUT - 1);
            state_nxt = WAIT_IDLE;
          end else begin
            err_code_nxt = ERR_NOACK;
            err_nxt      = 1'b1;
            data_oe_nxt  = 1'b0;
            state_nxt    = IDLE;
          end
        end else if (cnt == '0) begin
          err_code_nxt = ERR_BIT;
          err_nxt      = 1'b1;
          data_oe_nxt  = 1'b0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_filt && data_sync) begin
          done_nxt    = 1'b1;
          data_oe_nxt = 1'b0;
          state_nxt   = IDLE;
        end else if (cnt == '0) begin
          err_code_nxt = ERR_BIT;
          err_nxt      = 1'b1;
          data_oe_nxt  = 1'b0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        data_oe_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
  assign ps2_data_oe = data_oe_r;
  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign err_code    = err_code_r;

endmodule
